// File: rtl/burst_grant_arb_pkg.sv
// burst_grant_arb shared types, default sizes and count-slice helper.
// Optional GAP state is enabled by BURST_GRANT_ARB_GAP_EN.
package burst_grant_arb_pkg;

  localparam int BGA_N_CH  = 4;
  localparam int BGA_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } bga_state_e;

  function automatic logic [15:0] bga_slice_cnt(
    input logic [255:0] v,
    input int unsigned  i,
    input int unsigned  w
  );
    logic [15:0] mask;
    mask = (16'd1 << w) - 16'd1;
    return 16'(v >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/burst_grant_arb_if.sv
// Request/grant bundle between requesters and burst_grant_arb.
// Same bundle is used with or without BURST_GRANT_ARB_GAP_EN.
interface burst_grant_arb_if
  import burst_grant_arb_pkg::*;
#(
  parameter int N_CH  = BGA_N_CH,
  parameter int CNT_W = BGA_CNT_W
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       req;
  logic [N_CH*CNT_W-1:0] num_grants;
  logic [N_CH-1:0]       gnt;
  logic [N_CH-1:0]       last;
  logic [ID_W-1:0]       gnt_id;
  logic                  busy;

  modport master (
    output req, num_grants,
    input  gnt, last, gnt_id, busy
  );

  modport slave (
    input  req, num_grants,
    output gnt, last, gnt_id, busy
  );
endinterface

// File: rtl/bga_rr_arbiter.sv
// Combinational round-robin pick starting at ptr.
// Independent of BURST_GRANT_ARB_GAP_EN.
module bga_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] cand,
  input  logic [ID_W-1:0] ptr,
  output logic [N_CH-1:0] win_oh,
  output logic [ID_W-1:0] win_id,
  output logic            win_vld
);
  always_comb begin
    int idx;
    win_oh  = '0;
    win_id  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!win_vld && cand[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_id      = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/burst_grant_arb.sv
// Round-robin arbiter granting programmed consecutive-cycle bursts.
// Define BURST_GRANT_ARB_GAP_EN for one idle cycle after each burst.
module burst_grant_arb
  import burst_grant_arb_pkg::*;
#(
  parameter int N_CH  = BGA_N_CH,
  parameter int CNT_W = BGA_CNT_W
) (
  input logic              clk,
  input logic              reset,
  burst_grant_arb_if.slave bus
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  bga_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, win_cnt;
  logic [ID_W-1:0] id_q, id_n, ptr, ptr_n, win_id;
  logic [N_CH-1:0] pending, pending_n, req_q;
  logic [N_CH-1:0] rise, cand, act_oh, id_oh, win_oh;
  logic            zl, zl_n, win_vld, take;

  assign id_oh  = N_CH'(1) << id_q;
  assign rise   = bus.req & ~req_q;
  // the channel in service (burst or zero pulse) ignores its own rises
  assign act_oh = (state == GRANT || zl) ? id_oh : '0;
  assign cand   = pending | (rise & ~act_oh);

  bga_rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_arb (
    .cand    (cand),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  assign win_cnt = CNT_W'(bga_slice_cnt(
    256'(bus.num_grants), 32'(win_id), CNT_W));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    id_n    = id_q;
    ptr_n   = ptr;
    zl_n    = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (zl) begin
`ifdef BURST_GRANT_ARB_GAP_EN
          state_n = GAP;
`endif
        end else begin
          take = win_vld;
        end
      end
      GRANT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
`ifdef BURST_GRANT_ARB_GAP_EN
          state_n = GAP;
`else
          state_n = IDLE;
          take    = win_vld;
`endif
        end
      end
`ifdef BURST_GRANT_ARB_GAP_EN
      GAP: begin
        state_n = IDLE;
        take    = win_vld;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (take) begin
      cnt_n = win_cnt;
      id_n  = win_id;
      ptr_n = (win_id == ID_W'(N_CH - 1)) ? '0 : win_id + 1'b1;
      if (win_cnt == '0) begin
        zl_n    = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = GRANT;
      end
    end
    pending_n = (pending | (rise & ~act_oh)) & ~(take ? win_oh : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      id_q    <= '0;
      ptr     <= '0;
      pending <= '0;
      req_q   <= '0;
      zl      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      id_q    <= id_n;
      ptr     <= ptr_n;
      pending <= pending_n;
      req_q   <= bus.req;
      zl      <= zl_n;
    end
  end

  assign bus.gnt    = (state == GRANT) ? id_oh : '0;
  assign bus.last   = ((state == GRANT && cnt == CNT_W'(1)) || zl) ? id_oh : '0;
  assign bus.busy   = (state == GRANT);
  assign bus.gnt_id = id_q;
endmodule
